// File: rtl/resp_misr_if.sv
// Handshake bundle between a benchmark response source and the MISR compactor.
interface resp_misr_if #(
  parameter int RESP_W   = 6,
  parameter int SIG_W    = 16,
  parameter int PATTERNS = 8
);
  localparam int CNT_W = $clog2(PATTERNS + 1);

  logic              start;
  logic              resp_valid;
  logic [RESP_W-1:0] resp_data;
  logic              resp_ready;
  logic              busy;
  logic [CNT_W-1:0]  pat_cnt;
  logic              sig_valid;
  logic [SIG_W-1:0]  sig_data;
  logic              pass;
  logic              sig_ack;

  modport master (
    output start, resp_valid, resp_data, sig_ack,
    input  resp_ready, busy, pat_cnt, sig_valid, sig_data, pass
  );

  modport slave (
    input  start, resp_valid, resp_data, sig_ack,
    output resp_ready, busy, pat_cnt, sig_valid, sig_data, pass
  );
endinterface

// File: rtl/resp_misr_compactor.sv
// Folds PATTERNS response vectors into a SIG_W-bit MISR and reports the
// final signature with a pass flag against GOLDEN.
module resp_misr_compactor #(
  parameter int               RESP_W   = 6,
  parameter int               SIG_W    = 16,
  parameter int               PATTERNS = 8,
  parameter logic [SIG_W-1:0] POLY     = 16'h1021,
  parameter logic [SIG_W-1:0] SEED     = 16'hFFFF,
  parameter logic [SIG_W-1:0] GOLDEN   = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  resp_misr_if.slave   bus
);
  localparam int               CNT_W = $clog2(PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_accept;

  // One MISR shift: Galois feedback on the outgoing MSB, response folded into the low bits.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [RESP_W-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : '0;
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(d);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.resp_valid) begin
          w_accept = 1'b1;
          if (r_cnt == LAST) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.sig_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Signature and count hold in IDLE/DONE so the last result stays readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sig <= SEED;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sig <= misr_step(r_sig, bus.resp_data);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.resp_ready = (r_state == S_RUN);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sig_valid  = (r_state == S_DONE);
  assign bus.pass       = (r_state == S_DONE) && (r_sig == GOLDEN);
  assign bus.pat_cnt    = r_cnt;
  assign bus.sig_data   = r_sig;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Bench for resp_misr_compactor: a single-vector instance (PATTERNS=1) and an
// exhaustive-sweep instance (PATTERNS=8) checked against a transaction-level model.
module tb_resp_misr_compactor;
  logic       clk = 1'b0;
  logic       rst;
  logic       st  [2];
  logic       rv  [2];
  logic [5:0] rd  [2];
  logic       ack [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  resp_misr_if #(.RESP_W(6), .SIG_W(16), .PATTERNS(1)) bus0 ();
  resp_misr_if #(.RESP_W(6), .SIG_W(16), .PATTERNS(8)) bus1 ();

  assign bus0.start = st[0];  assign bus0.resp_valid = rv[0];
  assign bus0.resp_data = rd[0];  assign bus0.sig_ack = ack[0];
  assign bus1.start = st[1];  assign bus1.resp_valid = rv[1];
  assign bus1.resp_data = rd[1];  assign bus1.sig_ack = ack[1];

  resp_misr_compactor #(.RESP_W(6), .SIG_W(16), .PATTERNS(1),
                        .POLY(16'h1021), .SEED(16'hFFFF), .GOLDEN(16'hEFE0))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  resp_misr_compactor #(.RESP_W(6), .SIG_W(16), .PATTERNS(8),
                        .POLY(16'h1021), .SEED(16'hFFFF), .GOLDEN(16'h0000))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo the feedback polynomial, add the vector.
  function automatic int fold_vecs(input int v[8], input int n);
    int s;
    s = 'hFFFF;
    for (int i = 0; i < n; i++) begin
      s = s * 2;
      if (s >= 'h10000) s = (s - 'h10000) ^ 'h1021;
      s = s ^ v[i];
    end
    return s;
  endfunction

  // Transaction model: a run is the list of vectors taken since the last start.
  bit m_run  [2];
  bit m_done [2];
  int m_vec  [2][8];
  int m_n    [2];

  function automatic int pat_of(input int k);
    return (k == 0) ? 1 : 8;
  endfunction
  function automatic int gold_of(input int k);
    return (k == 0) ? 'hEFE0 : 'h0000;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] = 0; m_done[k] = 0; m_n[k] = 0;
      end else if (m_done[k]) begin
        if (ack[k]) m_done[k] = 0;
      end else if (m_run[k]) begin
        if (rv[k]) begin
          m_vec[k][m_n[k]] = int'(rd[k]);
          m_n[k]++;
          if (m_n[k] == pat_of(k)) begin
            m_run[k] = 0; m_done[k] = 1;
          end
        end
      end else if (st[k]) begin
        m_run[k] = 1; m_n[k] = 0;
      end
    end
  endtask

  task automatic model_compare();
    int o_rdy, o_busy, o_cnt, o_vld, o_sig, o_pass, exp_sig, v[8];
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o_rdy = int'(bus0.resp_ready); o_busy = int'(bus0.busy); o_cnt = int'(bus0.pat_cnt);
        o_vld = int'(bus0.sig_valid); o_sig = int'(bus0.sig_data); o_pass = int'(bus0.pass);
      end else begin
        o_rdy = int'(bus1.resp_ready); o_busy = int'(bus1.busy); o_cnt = int'(bus1.pat_cnt);
        o_vld = int'(bus1.sig_valid); o_sig = int'(bus1.sig_data); o_pass = int'(bus1.pass);
      end
      for (int i = 0; i < 8; i++) v[i] = m_vec[k][i];
      exp_sig = fold_vecs(v, m_n[k]);
      chk($sformatf("u%0d.resp_ready", k), o_rdy, int'(m_run[k]));
      chk($sformatf("u%0d.busy", k), o_busy, int'(m_run[k] | m_done[k]));
      chk($sformatf("u%0d.pat_cnt", k), o_cnt, m_n[k]);
      chk($sformatf("u%0d.sig_valid", k), o_vld, int'(m_done[k]));
      chk($sformatf("u%0d.sig_data", k), o_sig, exp_sig);
      chk($sformatf("u%0d.pass", k), o_pass, int'(m_done[k] && exp_sig == gold_of(k)));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vec[8];
  int pin[8];
  int hold_sig;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 0; rv[k] = 0; rd[k] = '0; ack[k] = 0;
    end

    // Hand-computed values pinning the model
    for (int i = 0; i < 8; i++) pin[i] = 0;
    chk("model_seed", fold_vecs(pin, 0), 'hFFFF);
    chk("model_one_00", fold_vecs(pin, 1), 'hEFDF);
    pin[0] = 'h3F;
    chk("model_one_3f", fold_vecs(pin, 1), 'hEFE0);

    // Reset and idle
    step(); step();
    rst = 1'b0;
    chk("rst_ready", int'(bus1.resp_ready), 0);
    chk("rst_valid", int'(bus1.sig_valid), 0);
    chk("rst_pass", int'(bus1.pass), 0);
    chk("rst_cnt", int'(bus1.pat_cnt), 0);
    chk("rst_busy", int'(bus1.busy), 0);
    chk("rst_sig", int'(bus1.sig_data), 'hFFFF);
    rv[0] = 1; rv[1] = 1; rd[0] = 6'h15; rd[1] = 6'h2A;
    step(); step();
    rv[0] = 0; rv[1] = 0;
    chk("idle_rv_sig0", int'(bus0.sig_data), 'hFFFF);
    chk("idle_rv_sig1", int'(bus1.sig_data), 'hFFFF);

    // Single-vector runs with pass flag
    for (int r = 0; r < 2; r++) begin
      st[0] = 1; step(); st[0] = 0;
      chk("single_ready", int'(bus0.resp_ready), 1);
      rv[0] = 1; rd[0] = (r == 0) ? 6'h00 : 6'h3F;
      step(); rv[0] = 0;
      chk("single_valid", int'(bus0.sig_valid), 1);
      chk("single_sig", int'(bus0.sig_data), (r == 0) ? 'hEFDF : 'hEFE0);
      chk("single_pass", int'(bus0.pass), r);
      chk("single_cnt", int'(bus0.pat_cnt), 1);
      ack[0] = 1; step(); ack[0] = 0;
      chk("single_ack_valid", int'(bus0.sig_valid), 0);
      chk("single_retain", int'(bus0.sig_data), (r == 0) ? 'hEFDF : 'hEFE0);
    end

    // Full sweep with alternate-cycle stalls
    for (int i = 0; i < 8; i++) vec[i] = int'($urandom_range(0, 63));
    st[1] = 1; step(); st[1] = 0;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_cnt_pre", int'(bus1.pat_cnt), i);
      rv[1] = 1; rd[1] = 6'(vec[i]);
      step(); rv[1] = 0;
      chk("sweep_cnt_post", int'(bus1.pat_cnt), i + 1);
      chk("sweep_valid", int'(bus1.sig_valid), (i == 7) ? 1 : 0);
      step();
      chk("sweep_cnt_stall", int'(bus1.pat_cnt), i + 1);
    end
    chk("sweep_sig", int'(bus1.sig_data), fold_vecs(vec, 8));

    // DONE held for 5 cycles with stray resp_valid and start
    hold_sig = fold_vecs(vec, 8);
    for (int c = 0; c < 5; c++) begin
      rv[1] = 1; rd[1] = 6'h3F; st[1] = (c % 2 == 0);
      step();
      chk("done_valid_hold", int'(bus1.sig_valid), 1);
      chk("done_sig_hold", int'(bus1.sig_data), hold_sig);
      chk("done_cnt_hold", int'(bus1.pat_cnt), 8);
    end
    rv[1] = 0;
    st[1] = 1; ack[1] = 1; step(); st[1] = 0; ack[1] = 0;
    chk("ack_start_busy", int'(bus1.busy), 0);
    step();
    chk("ack_start_no_run", int'(bus1.busy), 0);

    // Reset mid-run, then an uninterrupted run over the same vectors
    st[1] = 1; step(); st[1] = 0;
    for (int i = 0; i < 3; i++) begin
      rv[1] = 1; rd[1] = 6'(vec[i]); step();
    end
    rv[1] = 0;
    chk("midrun_cnt", int'(bus1.pat_cnt), 3);
    rst = 1; step(); rst = 0;
    chk("midrst_busy", int'(bus1.busy), 0);
    chk("midrst_cnt", int'(bus1.pat_cnt), 0);
    chk("midrst_sig", int'(bus1.sig_data), 'hFFFF);
    st[1] = 1; step(); st[1] = 0;
    for (int i = 0; i < 8; i++) begin
      rv[1] = 1; rd[1] = 6'(vec[i]); step();
    end
    rv[1] = 0; ack[1] = 1;
    chk("rerun_valid", int'(bus1.sig_valid), 1);
    chk("rerun_sig", int'(bus1.sig_data), fold_vecs(vec, 8));
    step(); ack[1] = 0;
    chk("rerun_idle", int'(bus1.busy), 0);

    // Randomized traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        st[k]  = ($urandom_range(0, 7) == 0);
        rv[k]  = ($urandom_range(0, 2) != 0);
        rd[k]  = 6'($urandom_range(0, 63));
        ack[k] = ($urandom_range(0, 3) == 0);
      end
      step();
    end
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      st[k] = 0; rv[k] = 0; ack[k] = 0;
    end
    step(); step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
